nibble_serial_add_ctrl: RTL and testbench

- Sequences a single 4-bit ripple-carry slice across a WIDTH-bit operand pair, one nibble per clock, LSB nibble first.
- The carry is held in a flip-flop between nibbles.
- Provides a valid/ready request interface and a valid/ready result interface, so an area-lean wide adder can be built from the existing 4-bit adder datapath.
- Sits between an operand source (register file or test sequencer) and a result consumer.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 28 ++
 rtl/nibble_serial_add_ctrl_add4.sv | 36 +++
 rtl/nibble_serial_add_ctrl.sv | 158 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl_pkg
// Shared definitions for the nibble-serial adder controller:
//   - controller state encoding (the unused code 2'd3 falls back to IDLE)
//   - nibble count derivation from the operand width
//   - nibble index width (never narrower than one bit)
// ---------------------------------------------------------------------------
package nibble_serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int NIBBLE_BITS = 4;

   // Number of 4-bit slices needed to cover a WIDTH-bit operand.
   function automatic int nib_count(input int width);
      return width / NIBBLE_BITS;
   endfunction

   // Index register width; a single-nibble build still gets a 1-bit index.
   function automatic int idx_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_add4.sv
// ---------------------------------------------------------------------------
// nibble_add4
// Purely combinational 4-bit ripple-carry adder slice.
// Ports:
//   x, y : 4-bit addends
//   ci   : carry into bit 0
//   s    : 4-bit sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (used for signed-overflow detection)
// ---------------------------------------------------------------------------
module nibble_add4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       c3
);

   // c[i] is the carry into bit i; c[4] is the carry out of the slice.
   logic [4:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < 4; i++) begin
         s[i]     = x[i] ^ y[i] ^ c[i];
         c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co = c[4];
   assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
// Wide adder built from a single 4-bit ripple slice that is stepped across
// the operands one nibble per clock, LSB nibble first, with the carry held in
// a flop between nibbles.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake; a, b, cin sampled on accept
//   a, b, cin             : WIDTH-bit operands and carry-in
//   out_valid / out_ready : result handshake
//   sum                   : a + b + cin modulo 2^WIDTH
//   cout                  : carry out of bit WIDTH-1
//   ovf                   : signed overflow (carry into MSB ^ carry out)
// Parameter WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int              NIB      = nib_count(WIDTH);
   localparam int              IDXW     = idx_width(NIB);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   state_e            state_q;
   state_e            state_d;

   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry_q;
   logic [IDXW-1:0]   idx_q;
   logic [WIDTH-1:0]  sum_q;
   logic [WIDTH-1:0]  sum_d;
   logic              cout_q;
   logic              ovf_q;

   logic              accept;
   logic              run_en;
   logic              last_nib;

   logic [3:0]        a_nib [NIB];
   logic [3:0]        b_nib [NIB];
   logic [3:0]        slice_s;
   logic              slice_co;
   logic              slice_c3;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)              state_d = ST_RUN;
         ST_RUN:  if (idx_q == LAST_IDX)     state_d = ST_DONE;
         ST_DONE: if (out_ready)             state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Handshake outputs (decoded from state only, so never both high)
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: in_ready  = 1'b1;
         ST_DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign run_en   = (state_q == ST_RUN);
   assign last_nib = run_en && (idx_q == LAST_IDX);

   // ------------------------------------------------------------------
   // Nibble views of the latched operands and per-nibble sum write-back.
   // Only the nibble addressed by idx is overwritten, and only in RUN.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
      assign sum_d[4*gi +: 4] = (run_en && (idx_q == IDXW'(gi))) ? slice_s
                                                                 : sum_q[4*gi +: 4];
   end

   // The carry flop is loaded with cin on accept, so it already feeds
   // nibble 0 correctly without a separate mux.
   nibble_add4 u_add4 (
      .x  (a_nib[idx_q]),
      .y  (b_nib[idx_q]),
      .ci (carry_q),
      .s  (slice_s),
      .co (slice_co),
      .c3 (slice_c3)
   );

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
         end else if (run_en) begin
            carry_q <= slice_co;
            idx_q   <= last_nib ? '0 : idx_q + IDXW'(1);
         end
         sum_q <= sum_d;
         if (last_nib) begin
            cout_q <= slice_co;
            ovf_q  <= slice_c3 ^ slice_co;
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
// Self-checking bench: spec vector table, hand-written handshake / reset
// sequences, and random vectors checked against an arithmetic model.
// A second instance is built at WIDTH=4.
// ---------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

   localparam int NIB16 = 4;
   localparam int NIB4  = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;

   logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
   logic [3:0]  a4, b4, sum4;

   int n_checks = 0;
   int n_fail   = 0;

   nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      string       name;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned and signed integer arithmetic at width w.
   task automatic model(input int w, input logic [15:0] x, input logic [15:0] y,
                        input logic c, output logic [15:0] s, output logic co,
                        output logic ov);
      longint m    = longint'(1) << w;
      longint half = m / 2;
      longint ux   = longint'(x);
      longint uy   = longint'(y);
      longint full = ux + uy + longint'(c);
      longint sx   = (ux >= half) ? ux - m : ux;
      longint sy   = (uy >= half) ? uy - m : uy;
      longint ss   = sx + sy + longint'(c);
      s  = 16'(full % m);
      co = (full >= m);
      ov = (ss < -half) || (ss >= half);
   endtask

   // Handshake invariant: in_ready and out_valid never high together.
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (in_ready && out_valid) begin
            n_fail++;
            $display("FAIL ready_valid_excl: in_ready=1 out_valid=1, required not both");
         end
      end
   end

   // One full 16-bit transaction; inputs are scrambled during RUN and the
   // result is held under backpressure for 'hold' cycles before handoff.
   task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input string name, input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "/in_ready"}, 32'(in_ready), 32'd1);
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "/latency"}, 32'(n), 32'(NIB16));
      check({name, "/sum"},  32'(sum),  32'(es));
      check({name, "/cout"}, 32'(cout), 32'(ec));
      check({name, "/ovf"},  32'(ovf),  32'(eo));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, "/hold_valid"}, 32'(out_valid), 32'd1);
         check({name, "/hold_sum"},   32'(sum),       32'(es));
         check({name, "/hold_ready"}, 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "/handoff"}, 32'(out_valid), 32'd0);
      $display("txn %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d (exp %h %0d %0d)",
               name, xa, xb, xc, sum, cout, ovf, es, ec, eo);
   endtask

   task automatic run4(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                       input logic [3:0] es, input logic ec, input logic eo,
                       input string name);
      int n;
      check({name, "/in_ready"}, 32'(in_ready4), 32'd1);
      a4 = xa; b4 = xb; cin4 = xc; in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      n = 0;
      while (!out_valid4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "/latency"}, 32'(n), 32'(NIB4));
      check({name, "/sum"},  32'(sum4),  32'(es));
      check({name, "/cout"}, 32'(cout4), 32'(ec));
      check({name, "/ovf"},  32'(ovf4),  32'(eo));
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
      check({name, "/handoff"}, 32'(out_valid4), 32'd0);
      $display("txn %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d (exp %h %0d %0d)",
               name, xa, xb, xc, sum4, cout4, ovf4, es, ec, eo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] xa, xb, es;
      logic        xc, ec, eo;
      int          n, seen;

      vecs[0] = '{16'hAAAA, 16'hAAAA, 1'b0, 16'h5554, 1'b1, 1'b1, "aaaa_aaaa"};
      vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "ffff_cin"};
      vecs[2] = '{16'h8000, 16'hC000, 1'b0, 16'h4000, 1'b1, 1'b1, "8000_c000"};
      vecs[3] = '{16'h0003, 16'h000F, 1'b0, 16'h0012, 1'b0, 1'b0, "0003_000f"};

      in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
      in_valid4 = 0; out_ready4 = 0; a4 = '0; b4 = '0; cin4 = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst/in_ready",  32'(in_ready),  32'd1);
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/sum",       32'(sum),       32'd0);
      check("rst/cout",      32'(cout),      32'd0);
      check("rst/ovf",       32'(ovf),       32'd0);
      check("rst4/in_ready", 32'(in_ready4), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Spec vectors; the first carries a 5-cycle backpressure hold.
      for (int i = 0; i < 4; i++) begin
         run16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
               vecs[i].ovf, vecs[i].name, (i == 0) ? 5 : 0);
      end

      // Busy request: B held on the inputs through A's RUN and DONE.
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("busy_a/latency", 32'(n), 32'(NIB16));
      check("busy_a/sum",     32'(sum), 32'h3333);
      check("busy_a/cout",    32'(cout), 32'd0);
      check("busy_a/in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("busy/idle_valid", 32'(out_valid), 32'd0);
      check("busy/idle_ready", 32'(in_ready),  32'd1);
      @(negedge clk);
      check("busy_b/accepted", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("busy_b/latency", 32'(n), 32'(NIB16));
      check("busy_b/sum",     32'(sum),  32'h8000);
      check("busy_b/cout",    32'(cout), 32'd0);
      check("busy_b/ovf",     32'(ovf),  32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      $display("txn busy: a=1111+2222 then 7fff+0001 handed off in order");

      // Leave cout/ovf at 1 so the reset clearing them is observable.
      run16(16'h8000, 16'hC000, 1'b0, 16'h4000, 1'b1, 1'b1, "pre_reset", 0);

      // Reset at idx=2 of a RUN.
      a = 16'hAAAA; b = 16'hAAAA; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrun/partial_sum", 32'(sum[7:0]), 32'h54);
      rst_n = 1'b0;
      #1;
      check("midrun/sum",       32'(sum),       32'd0);
      check("midrun/cout",      32'(cout),      32'd0);
      check("midrun/ovf",       32'(ovf),       32'd0);
      check("midrun/in_ready",  32'(in_ready),  32'd1);
      check("midrun/out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < NIB16 + 4; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrun/no_out_valid", 32'(seen), 32'd0);
      $display("txn midrun_reset: aborted at idx=2");
      run16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "after_reset", 0);

      // Random vectors against the arithmetic model.
      for (int i = 0; i < 20; i++) begin
         xa = 16'($urandom);
         xb = 16'($urandom);
         xc = 1'($urandom);
         if (i % 5 == 0) xb = ~xa;
         model(16, xa, xb, xc, es, ec, eo);
         run16(xa, xb, xc, es, ec, eo, "rand16", int'($urandom_range(0, 2)));
      end

      // WIDTH=4 build.
      run4(4'hA, 4'h6, 1'b0, 4'h0, 1'b1, 1'b0, "w4_a_6");
      for (int i = 0; i < 8; i++) begin
         xa = {12'h0, 4'($urandom)};
         xb = {12'h0, 4'($urandom)};
         xc = 1'($urandom);
         model(4, xa, xb, xc, es, ec, eo);
         run4(xa[3:0], xb[3:0], xc, es[3:0], ec, eo, "rand4");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
